// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: derives sclk/ws from clk and shifts out stereo samples MSB-first.
// A one-deep holding buffer absorbs jitter between the EQ strobe and the frame rate.
module i2s_tx_serializer #(
  parameter int SCLK_DIV = 16,
  parameter int SMPL_W   = 16,
  parameter int SLOT_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [SMPL_W-1:0] aud_lft,
  input  logic [SMPL_W-1:0] aud_rght,
  output logic              rdy,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data,
  output logic              underrun,
  output logic              overrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(SCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int PAD     = SLOT_W - SMPL_W;

  logic [CNT_W-1:0]   r_sclk_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [FRAME_W-1:0] r_frame;
  logic [SMPL_W-1:0]  r_hold_lft;
  logic [SMPL_W-1:0]  r_hold_rght;
  logic               r_full;
  logic               r_rdy;
  logic               r_sclk;
  logic               r_ws;
  logic               r_underrun;
  logic               r_overrun;

  logic [CNT_W-1:0]   w_sclk_cnt_next;
  logic [BIT_W-1:0]   w_bit_next;
  logic [FRAME_W-1:0] w_load;
  logic [FRAME_W-1:0] w_frame_next;
  logic               w_fall;
  logic               w_boundary;
  logic               w_ws_next;
  logic               w_full_next;

  assign w_fall          = (r_sclk_cnt == CNT_W'(SCLK_DIV - 1));
  assign w_sclk_cnt_next = w_fall ? '0 : r_sclk_cnt + CNT_W'(1);
  assign w_boundary      = w_fall && (r_bit_cnt == BIT_W'(FRAME_W - 1));
  assign w_bit_next      = w_boundary ? '0 : r_bit_cnt + BIT_W'(1);
  assign w_ws_next       = (w_bit_next >= BIT_W'(SLOT_W - 1)) &&
                           (w_bit_next <= BIT_W'(FRAME_W - 2));

  // Whole frame is laid out MSB-first so each falling event just shifts left by one.
  always_comb begin
    w_load = '0;
    if (r_full) begin
      w_load = {SLOT_W'(r_hold_lft) << PAD, SLOT_W'(r_hold_rght) << PAD};
    end
  end

  assign w_frame_next = w_boundary ? w_load : {r_frame[FRAME_W-2:0], 1'b0};

  // A boundary always drains the buffer, so only a coincident strobe keeps it full.
  assign w_full_next  = w_boundary ? vld : (r_full | vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_frame     <= '0;
      r_hold_lft  <= '0;
      r_hold_rght <= '0;
      r_full      <= 1'b0;
      r_rdy       <= 1'b1;
      r_sclk      <= 1'b0;
      r_ws        <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sclk_cnt <= w_sclk_cnt_next;
      r_sclk     <= (w_sclk_cnt_next >= CNT_W'(SCLK_DIV / 2));
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_ws      <= w_ws_next;
        r_frame   <= w_frame_next;
      end
      if (vld) begin
        r_hold_lft  <= aud_lft;
        r_hold_rght <= aud_rght;
      end
      r_full     <= w_full_next;
      r_rdy      <= !w_full_next;
      r_underrun <= w_boundary && !r_full;
      r_overrun  <= vld && r_full && !w_boundary;
    end
  end

  assign rdy      = r_rdy;
  assign I2S_sclk = r_sclk;
  assign I2S_ws   = r_ws;
  assign I2S_data = r_frame[FRAME_W-1];
  assign underrun = r_underrun;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench: a frame-level buffer model predicts transmitted frames and pulse cycles;
// a separate negedge monitor reassembles frames from I2S_data on sclk rising edges.
module tb_i2s_tx_serializer;
  localparam int SCLK_DIV  = 16;
  localparam int SMPL_W    = 16;
  localparam int SLOT_W    = 24;
  localparam int FRAME_B   = 2 * SLOT_W;
  localparam int FRAME_CYC = FRAME_B * SCLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic [SMPL_W-1:0] aud_lft = '0;
  logic [SMPL_W-1:0] aud_rght = '0;
  logic rdy, I2S_sclk, I2S_ws, I2S_data, underrun, overrun;

  i2s_tx_serializer #(.SCLK_DIV(SCLK_DIV), .SMPL_W(SMPL_W), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst(rst), .vld(vld), .aud_lft(aud_lft), .aud_rght(aud_rght),
    .rdy(rdy), .I2S_sclk(I2S_sclk), .I2S_ws(I2S_ws), .I2S_data(I2S_data),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;                       // clock edges since reset released
  logic [FRAME_B-1:0] frame_q[$];
  int uq[$];
  int oq[$];
  bit m_full = 1'b0;
  logic [SMPL_W-1:0] m_l = '0, m_r = '0;
  bit exp_rdy = 1'b1, exp_rdy_pend = 1'b1;
  bit mon_clear = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, n);
  endtask

  // Bit b of a frame: slot position p = b mod SLOT_W, sample bits MSB-first then zero pad.
  function automatic logic [FRAME_B-1:0] make_frame(input logic [SMPL_W-1:0] l,
                                                    input logic [SMPL_W-1:0] r);
    logic [FRAME_B-1:0] f;
    logic [SMPL_W-1:0] ch;
    int p;
    f = '0;
    for (int b = 0; b < FRAME_B; b++) begin
      p  = b % SLOT_W;
      ch = (b < SLOT_W) ? l : r;
      f[FRAME_B-1-b] = (p < SMPL_W) ? ch[SMPL_W-1-p] : 1'b0;
    end
    return f;
  endfunction

  task automatic model(input int e, input bit v, input logic [SMPL_W-1:0] l,
                       input logic [SMPL_W-1:0] r);
    if (e % FRAME_CYC == 0) begin
      if (m_full) frame_q.push_back(make_frame(m_l, m_r));
      else begin
        frame_q.push_back('0);
        uq.push_back(e);
      end
      m_full = v;
      if (v) begin m_l = l; m_r = r; end
    end else if (v) begin
      if (m_full) oq.push_back(e);
      m_full = 1'b1;
      m_l = l;
      m_r = r;
    end
    exp_rdy_pend = !m_full;
  endtask

  task automatic step(input bit v, input logic [SMPL_W-1:0] l, input logic [SMPL_W-1:0] r);
    vld = v;
    aud_lft = l;
    aud_rght = r;
    model(n + 1, v, l, r);
    @(posedge clk);
    n++;
    exp_rdy = exp_rdy_pend;
    #1;
    vld = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (n < target) step(1'b0, '0, '0);
  endtask

  task automatic end_phase();
    @(negedge clk);
    #1;
    check("pending_underrun", 64'(uq.size()), 64'd0);
    check("pending_overrun", 64'(oq.size()), 64'd0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    vld = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
    check("reset_outputs", {58'd0, I2S_sclk, I2S_ws, I2S_data, underrun, overrun, rdy},
          64'b000001);
    rst = 1'b0;
    n = 0;
    m_full = 1'b0;
    frame_q.delete();
    uq.delete();
    oq.delete();
    frame_q.push_back('0);
    exp_rdy = 1'b1;
    exp_rdy_pend = 1'b1;
    mon_clear = 1'b1;
  endtask

  initial begin : monitor
    logic [FRAME_B-1:0] f;
    logic [FRAME_B-1:0] e;
    int nb;
    logic prev;
    bit sclk_exp, ws_exp;
    int b;
    f = '0; nb = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_clear) begin
        f = '0; nb = 0; prev = 1'b0; mon_clear = 1'b0;
      end
      if (!rst) begin
        b = (n / SCLK_DIV) % FRAME_B;
        sclk_exp = (n % SCLK_DIV) >= SCLK_DIV / 2;
        ws_exp = (b >= SLOT_W - 1) && (b <= FRAME_B - 2);
        check("sclk_ws_rdy", {61'd0, I2S_sclk, I2S_ws, rdy}, {61'd0, sclk_exp, ws_exp, exp_rdy});
        if (I2S_sclk && !prev) begin
          f = {f[FRAME_B-2:0], I2S_data};
          nb++;
          if (nb == FRAME_B) begin
            nb = 0;
            if (frame_q.size() == 0) fail_now("frame", "frame transmitted with none expected");
            else begin
              e = frame_q.pop_front();
              check("frame", 64'(f), 64'(e));
            end
          end
        end
        prev = I2S_sclk;
        if (underrun) begin
          if (uq.size() == 0) fail_now("underrun", "pulse seen, none expected");
          else check("underrun_cycle", 64'(n), 64'(uq.pop_front()));
        end
        if (overrun) begin
          if (oq.size() == 0) fail_now("overrun", "pulse seen, none expected");
          else check("overrun_cycle", 64'(n), 64'(oq.pop_front()));
        end
      end
    end
  end

  initial begin : stimulus
    int gap;
    do_reset(3);
    // sample captured before the first boundary, carried by the second frame
    idle_until(9);
    step(1'b1, 16'hA5C3, 16'h1234);
    idle_until(3 * FRAME_CYC + 10);
    end_phase();

    // three frames of silence
    do_reset(2);
    idle_until(3 * FRAME_CYC + 5);
    end_phase();

    // two strobes in one frame: overrun, later sample wins
    do_reset(2);
    idle_until(99);
    step(1'b1, 16'h0001, 16'h0101);
    idle_until(199);
    step(1'b1, 16'h8000, 16'h0202);
    idle_until(2 * FRAME_CYC + 10);
    end_phase();

    // strobes coinciding with boundaries, first with full, then with empty buffer
    do_reset(2);
    idle_until(4);
    step(1'b1, 16'h7FFF, 16'h7FFE);
    idle_until(FRAME_CYC - 1);
    step(1'b1, 16'h4321, 16'hFEDC);
    idle_until(3 * FRAME_CYC - 1);
    step(1'b1, 16'h1357, 16'h2468);
    idle_until(4 * FRAME_CYC + 10);
    end_phase();

    // reset mid-frame at b=30 discards the buffered sample
    do_reset(2);
    idle_until(49);
    step(1'b1, 16'hCAFE, 16'hBEEF);
    idle_until(FRAME_CYC + 30 * SCLK_DIV + 3);
    step(1'b1, 16'h5555, 16'hAAAA);
    end_phase();
    do_reset(1);
    idle_until(FRAME_CYC + 10);
    end_phase();

    // randomized strobes roughly one per frame
    do_reset(2);
    for (int k = 0; k < 50; k++) begin
      gap = FRAME_CYC - 20 + int'($urandom_range(0, 40));
      idle_until(n + gap - 1);
      step(1'b1, 16'($urandom), 16'($urandom));
    end
    idle_until(n + 2 * FRAME_CYC);
    end_phase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
